// File: rtl/rtc_bus_pkg.sv
// Shared types and constants for the RTC multiplexed-bus sequencer.
package rtc_bus_pkg;

  // Sequencer states; each timed state lasts a programmable number of cycles.
  typedef enum logic [3:0] {
    StIdle,
    StAddrSetup,
    StAddrStrobe,
    StAddrHold,
    StGap,
    StDataSetup,
    StDataStrobe,
    StDataHold,
    StDone
  } state_e;

  // Default phase durations in clock cycles.
  localparam int unsigned T_SETUP_DEF = 2;
  localparam int unsigned T_PULSE_DEF = 10;
  localparam int unsigned T_HOLD_DEF  = 2;
  localparam int unsigned T_GAP_DEF   = 10;

  // Pin polarities.
  localparam logic CS_ACTIVE     = 1'b0;
  localparam logic STROBE_ACTIVE = 1'b0;
  localparam logic AOD_ADDR      = 1'b0;
  localparam logic AOD_DATA      = 1'b1;

endpackage

// File: rtl/rtc_bus_ctrl_if.sv
// Request/response and RTC pin bundle between TOP's register logic and the sequencer.
interface rtc_bus_ctrl_if;
  logic       req;
  logic       rw;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  logic       ChipSelect;
  logic       Read;
  logic       Write;
  logic       AoD;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic [7:0] bus_in;

  modport master (
    output req, rw, addr, wdata, bus_in,
    input  busy, done, rdata, ChipSelect, Read, Write, AoD, bus_out, bus_oe
  );

  modport slave (
    input  req, rw, addr, wdata, bus_in,
    output busy, done, rdata, ChipSelect, Read, Write, AoD, bus_out, bus_oe
  );
endinterface

// File: rtl/rtc_bus_timer.sv
// Loadable 8-bit down-counter; zero_o flags the last cycle of a timed state.
module rtc_bus_timer (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  output logic       zero_o
);
  logic [7:0] cnt_d, cnt_q;

  // Load on state entry, otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= 8'd0;
    else         cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == 8'd0);
endmodule

// File: rtl/rtc_bus_ctrl.sv
// Sequencer turning a one-cycle request into an RTC address phase plus data phase.
module rtc_bus_ctrl
  import rtc_bus_pkg::*;
#(
  parameter int unsigned T_SETUP = T_SETUP_DEF,
  parameter int unsigned T_PULSE = T_PULSE_DEF,
  parameter int unsigned T_HOLD  = T_HOLD_DEF,
  parameter int unsigned T_GAP   = T_GAP_DEF
) (
  input  logic         clk,
  input  logic         Reset,
  rtc_bus_ctrl_if.slave bus
);
  if (T_SETUP == 0 || T_PULSE == 0 || T_HOLD == 0 || T_GAP == 0 ||
      T_SETUP > 255 || T_PULSE > 255 || T_HOLD > 255 || T_GAP > 255) begin : g_bad_timing
    $error("rtc_bus_ctrl: timing parameters must lie in 1..255");
  end

  // Counter reload values: a state of N cycles starts at N-1.
  localparam logic [7:0] SetupM1 = 8'(T_SETUP - 1);
  localparam logic [7:0] PulseM1 = 8'(T_PULSE - 1);
  localparam logic [7:0] HoldM1  = 8'(T_HOLD - 1);
  localparam logic [7:0] GapM1   = 8'(T_GAP - 1);

  state_e     state_d, state_q;
  logic       rw_d, rw_q;
  logic [7:0] addr_d, addr_q, wdata_d, wdata_q, rdata_d, rdata_q;
  logic       cs_d, cs_q, rd_d, rd_q, wr_d, wr_q, aod_d, aod_q, oe_d, oe_q;
  logic [7:0] out_d, out_q;
  logic       busy_d, busy_q, done_d, done_q;
  logic       tmr_load, tmr_zero;
  logic [7:0] tmr_val;

  rtc_bus_timer u_timer (
    .clk_i      (clk),
    .rst_ni     (Reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .zero_o     (tmr_zero)
  );

  // Next state, request latching and read capture.
  always_comb begin
    state_d  = state_q;
    rw_d     = rw_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    tmr_load = 1'b0;
    tmr_val  = 8'd0;
    unique case (state_q)
      StIdle: if (bus.req) begin
        state_d  = StAddrSetup;
        rw_d     = bus.rw;
        addr_d   = bus.addr;
        wdata_d  = bus.wdata;
        tmr_load = 1'b1;
        tmr_val  = SetupM1;
      end
      StAddrSetup: if (tmr_zero) begin
        state_d = StAddrStrobe; tmr_load = 1'b1; tmr_val = PulseM1;
      end
      StAddrStrobe: if (tmr_zero) begin
        state_d = StAddrHold; tmr_load = 1'b1; tmr_val = HoldM1;
      end
      StAddrHold: if (tmr_zero) begin
        state_d = StGap; tmr_load = 1'b1; tmr_val = GapM1;
      end
      StGap: if (tmr_zero) begin
        state_d = StDataSetup; tmr_load = 1'b1; tmr_val = SetupM1;
      end
      StDataSetup: if (tmr_zero) begin
        state_d = StDataStrobe; tmr_load = 1'b1; tmr_val = PulseM1;
      end
      StDataStrobe: if (tmr_zero) begin
        state_d = StDataHold; tmr_load = 1'b1; tmr_val = HoldM1;
        // Capture on the last strobe cycle, while Read is still low.
        if (rw_q) rdata_d = bus.bus_in;
      end
      StDataHold: if (tmr_zero) begin
        state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Pin levels for the state being entered, so every output is a flop.
  always_comb begin
    cs_d   = !CS_ACTIVE;
    rd_d   = !STROBE_ACTIVE;
    wr_d   = !STROBE_ACTIVE;
    aod_d  = AOD_ADDR;
    oe_d   = 1'b0;
    out_d  = out_q;
    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
    case (state_d)
      StAddrSetup, StAddrHold, StAddrStrobe: begin
        cs_d  = CS_ACTIVE;
        oe_d  = 1'b1;
        out_d = addr_d;
        if (state_d == StAddrStrobe) wr_d = STROBE_ACTIVE;
      end
      StDataSetup, StDataStrobe, StDataHold: begin
        cs_d  = CS_ACTIVE;
        aod_d = AOD_DATA;
        oe_d  = !rw_d;
        if (!rw_d) out_d = wdata_d;
        if (state_d == StDataStrobe) begin
          if (rw_d) rd_d = STROBE_ACTIVE;
          else      wr_d = STROBE_ACTIVE;
        end
      end
      default: ;
    endcase
  end

  // State and registered outputs; reset abandons any transfer in flight.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= StIdle;
      rw_q    <= 1'b0;
      addr_q  <= 8'd0;
      wdata_q <= 8'd0;
      rdata_q <= 8'd0;
      cs_q    <= !CS_ACTIVE;
      rd_q    <= !STROBE_ACTIVE;
      wr_q    <= !STROBE_ACTIVE;
      aod_q   <= AOD_ADDR;
      oe_q    <= 1'b0;
      out_q   <= 8'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cs_q    <= cs_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      aod_q   <= aod_d;
      oe_q    <= oe_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.rdata      = rdata_q;
  assign bus.ChipSelect = cs_q;
  assign bus.Read       = rd_q;
  assign bus.Write      = wr_q;
  assign bus.AoD        = aod_q;
  assign bus.bus_out    = out_q;
  assign bus.bus_oe     = oe_q;
endmodule
